// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multicycle MIPS control sequencer: opcodes, state
// codes and datapath mux encodings.
package multicycle_control_pkg;

  typedef logic [5:0] opcode_t;

  localparam opcode_t OP_RTYPE = 6'h00;
  localparam opcode_t OP_J     = 6'h02;
  localparam opcode_t OP_BEQ   = 6'h04;
  localparam opcode_t OP_BNE   = 6'h05;
  localparam opcode_t OP_ADDI  = 6'h08;
  localparam opcode_t OP_LW    = 6'h23;
  localparam opcode_t OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EX     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       retire;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control-to-datapath bundle: instruction/memory status in, mux and enable
// lines out. master = sequencer, slave = datapath.
interface multicycle_control_if;
  import multicycle_control_pkg::*;

  opcode_t    opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       branch_ne;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       retire;
  logic       halted;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
           ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
           alu_op, pc_source, retire, halted
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
           ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
           alu_op, pc_source, retire, halted
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS control sequencer: one state register plus a combinational
// next-state/output decode, sharing a single memory port for fetch and data.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input logic                  clock,
  input logic                  reset,
  multicycle_control_if.master bus
);

  // state | meaning
  // FETCH    | read instruction at PC, PC+4 -> PC on mem_ready
  // DECODE   | register read, branch target -> ALUOut
  // MEM_ADDR | base + imm -> ALUOut
  // MEM_RD   | data read at ALUOut, wait for mem_ready
  // MEM_WB   | MDR -> rt, retire lw
  // MEM_WR   | data write at ALUOut, retire sw on mem_ready
  // R_EX     | A funct B -> ALUOut
  // R_WB     | ALUOut -> rd, retire
  // BRANCH   | compare A-B, conditional PC load, retire
  // JUMP     | jump target -> PC, retire
  // ADDI_EX  | A + imm -> ALUOut
  // ADDI_WB  | ALUOut -> rt, retire
  // HALT     | stopped until reset

  state_t state, state_nxt;
  ctrl_t  ctrl;

  always_ff @(posedge clock) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    ctrl      = '0;
    state_nxt = state;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = bus.mem_ready;
        ctrl.pc_write  = bus.mem_ready;
        if (bus.mem_ready) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_BRANCH;
        ctrl.alu_op    = ALU_ADD;
        case (bus.opcode)
          OP_RTYPE:      state_nxt = S_R_EX;
          OP_LW, OP_SW:  state_nxt = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_nxt = S_BRANCH;
          OP_ADDI:       state_nxt = S_ADDI_EX;
          OP_J:          state_nxt = S_JUMP;
          default: begin
            if (HALT_ON_ILLEGAL) begin
              state_nxt = S_HALT;
            end else begin
              state_nxt   = S_FETCH;
              ctrl.retire = 1'b1;
            end
          end
        endcase
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        state_nxt      = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
        if (bus.mem_ready) state_nxt = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.retire     = 1'b1;
        state_nxt       = S_FETCH;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
        ctrl.retire    = bus.mem_ready;
        if (bus.mem_ready) state_nxt = S_FETCH;
      end
      S_R_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
        state_nxt      = S_R_WB;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        ctrl.retire    = 1'b1;
        state_nxt      = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.branch_ne     = (bus.opcode == OP_BNE);
        ctrl.retire        = 1'b1;
        state_nxt          = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.retire    = 1'b1;
        state_nxt      = S_FETCH;
      end
      S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        state_nxt      = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.retire    = 1'b1;
        state_nxt      = S_FETCH;
      end
      S_HALT: begin
        ctrl.halted = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase
    // Reset silences the datapath in the same cycle, so nothing is written.
    if (!reset) ctrl = '0;
  end

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.branch_ne     = ctrl.branch_ne;
  assign bus.i_or_d        = ctrl.i_or_d;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.retire        = ctrl.retire;
  assign bus.halted        = ctrl.halted;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore/Mealy control sequencer for a multicycle MIPS datapath.
- Shares one memory port between instruction fetch and data access, and steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK.
- Drives every datapath mux, write-enable and ALU-op line of the CPU, with wait states on a memory-ready handshake.
- Emits a one-cycle retire pulse per completed instruction, for bench cycle/IPC accounting.

Parameters:
- HALT_ON_ILLEGAL, 1, 1: an unknown opcode enters HALT; 0: the instruction is retired as a NOP and the block returns to FETCH.

Ports:
- clock  input  1  rising-edge system clock
- reset  input  1  synchronous, active-low reset (sampled on clock rising edge)
- opcode  input  6  instr[31:26] from the instruction register
- mem_ready  input  1  memory access completes this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if the branch condition holds
- branch_ne  output  1  0 selects beq (take on zero); 1 selects bne (take on non-zero)
- i_or_d  output  1  memory address source: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  instruction register load
- mem_to_reg  output  1  register write data: 0 = ALUOut, 1 = MDR
- reg_dst  output  1  destination register: 0 = rt, 1 = rd
- reg_write  output  1  register file write enable
- alu_src_a  output  1  ALU A input: 0 = PC, 1 = register A
- alu_src_b  output  2  ALU B input: 00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- alu_op  output  2  00 = add, 01 = sub, 10 = funct field
- pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- retire  output  1  one-cycle pulse when an instruction completes
- halted  output  1  high while in HALT

Behaviour:
- State register is 4 bits wide. Encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EX=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11, HALT=12. Codes 13–15 go to FETCH.
- Reset: reset==0 at a clock edge sets state to FETCH. While reset is low, every output is forced to 0, including retire and halted. The first fetch request appears in the cycle after reset goes high. Reset mid-instruction abandons that instruction with no writes.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write equal mem_ready (Mealy).
  - Stay in FETCH while mem_ready==0; go to DECODE when it is 1.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target goes to ALUOut).
  - Next state by opcode: 0x00 → R_EX; 0x23 or 0x2B → MEM_ADDR; 0x04 or 0x05 → BRANCH; 0x08 → ADDI_EX; 0x02 → JUMP; anything else → HALT if HALT_ON_ILLEGAL, else FETCH with retire=1.
- MEM_ADDR:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next state: 0x23 → MEM_RD, 0x2B → MEM_WR.
  - Opcode is held stable by the IR, which is not written outside FETCH.
- MEM_RD: mem_read=1, i_or_d=1. Wait for mem_ready, then go to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, retire=1. Next state FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Wait for mem_ready. retire=mem_ready; go to FETCH when mem_ready.
- R_EX: alu_src_a=1, alu_src_b=00, alu_op=10. Next state R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, retire=1. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, branch_ne=(opcode==0x05), retire=1. Next state FETCH.
- JUMP: pc_write=1, pc_source=10, retire=1. Next state FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00. Next state ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, retire=1. Next state FETCH.
- HALT: halted=1, all other outputs 0. Only reset leaves HALT.
- Defaults: any output not listed for a state is 0.
- Invariants:
  - mem_read and mem_write are never both 1.
  - retire pulses exactly once per instruction.
- Latency with mem_ready tied to 1, in cycles:
  - lw 5; sw 4; R-type 4; addi 4; beq/bne 3; j 3.

Decomposition:
- Shared constants header (extending the existing constants header):
  - opcode values: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J
  - state codes
  - alu_op, alu_src_b and pc_source encodings
- Sub-modules: none. The block is one state register plus a combinational next-state/output decode.

Test Plan:
- Reset: hold reset=0 for 3 clocks, then release → all outputs 0 during reset. The next cycle is FETCH with mem_read=1, i_or_d=0.
- lw (opcode 0x23), mem_ready=1 → state sequence 0,1,2,3,4. reg_write=1 and mem_to_reg=1 in cycle 5. retire pulses once, in cycle 5.
- sw (opcode 0x2B), mem_ready low for 2 cycles in MEM_WR → mem_write=1 held for 3 cycles. No reg_write. retire only in the cycle where mem_ready=1.
- beq (0x04), then bne (0x05) → in cycle 3, pc_write_cond=1, pc_source=01, alu_op=01, with branch_ne=0 then 1 respectively.
- Illegal opcode 0x3F:
  - HALT_ON_ILLEGAL=1 → halted=1 stays high for 10 clocks; a later reset=0 returns to FETCH.
  - HALT_ON_ILLEGAL=0 → retire=1 in DECODE, then FETCH.
- Reset asserted in R_EX → the next state is FETCH, and reg_write is never asserted for the abandoned instruction.
